// File: rtl/shift_pkg.sv
// Shared encodings for the shift-register sequencer.
// Register mode codes, command codes and FSM state codes.
package shift_pkg;

    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_SHR  = 2'b01;
    localparam logic [1:0] S_SHL  = 2'b10;
    localparam logic [1:0] S_LOAD = 2'b11;

    localparam logic OP_NORM = 1'b0;
    localparam logic OP_SHR  = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_LOAD  = 2'b01;
    localparam logic [1:0] ST_SHIFT = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

endpackage

// File: rtl/shift_norm_ctrl.sv
// Normalize / right-shift sequencer driving a universal shift register.
// Build option SHIFT_ARITH_EN: sign-extending right shifts via SR.
module shift_norm_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             OP,
    input  logic [CNT_W-1:0] AMT,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic [WIDTH-1:0] Q,
    output logic [1:0]       S,
    output logic [WIDTH-1:0] D,
    output logic             SL,
    output logic             SR,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] SHIFT_CNT,
    output logic             ZERO
);

    logic [1:0]       state;
    logic             op_r;
    logic [CNT_W-1:0] amt_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] data_r;
    logic             term;
    logic             shifting;

    // The terminal check looks at Q as it stands after the previous shift.
    always_comb begin
        term = 1'b0;
        if (op_r == OP_SHR)
            term = (cnt == amt_r);
        else
            term = Q[WIDTH-1] || (Q == '0) ||
                   (cnt == CNT_W'(WIDTH-1));
        shifting = (state == ST_SHIFT) && !term;
    end

    always_comb begin
        S  = S_HOLD;
        D  = '0;
        SL = 1'b0;
        case (state)
            ST_LOAD: begin
                S = S_LOAD;
                D = data_r;
            end
            ST_SHIFT: begin
                if (shifting)
                    S = (op_r == OP_SHR) ? S_SHR : S_SHL;
            end
            default: S = S_HOLD;
        endcase
`ifdef SHIFT_ARITH_EN
        SR = shifting && (op_r == OP_SHR) && data_r[WIDTH-1];
`else
        SR = 1'b0;
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            op_r      <= OP_NORM;
            amt_r     <= '0;
            cnt       <= '0;
            data_r    <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            SHIFT_CNT <= '0;
            ZERO      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        op_r   <= OP;
                        amt_r  <= AMT;
                        data_r <= DATA_IN;
                        cnt    <= '0;
                        BUSY   <= 1'b1;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: state <= ST_SHIFT;
                ST_SHIFT: begin
                    if (term) begin
                        SHIFT_CNT <= cnt;
                        ZERO      <= (op_r == OP_NORM) && (Q == '0);
                        DONE      <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_norm_ctrl.sv
// Directed bench: sequencer plus a behavioural universal shift register.
module tb_shift_norm_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [4:0]  amt;
    logic [31:0] data_in;
    logic [31:0] q;
    logic [1:0]  s;
    logic [31:0] d;
    logic        sl;
    logic        sr;
    logic        busy;
    logic        done;
    logic [4:0]  shift_cnt;
    logic        zero;

    int vectors = 0;
    int fails   = 0;

    shift_norm_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .CLK(clk), .RST(rst_n), .START(start), .OP(op), .AMT(amt),
        .DATA_IN(data_in), .Q(q), .S(s), .D(d), .SL(sl), .SR(sr),
        .BUSY(busy), .DONE(done), .SHIFT_CNT(shift_cnt), .ZERO(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // universal shift register downstream of the sequencer
    always @(posedge clk) begin
        case (s)
            2'b01:   q <= {sr, q[31:1]};
            2'b10:   q <= {q[30:0], sl};
            2'b11:   q <= d;
            default: q <= q;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one command; pulse>0 strobes START at that cycle, hold keeps START high.
    task automatic run(input string tag, input logic o, input logic [4:0] a,
                       input logic [31:0] w, input int k,
                       input logic [31:0] exp_q, input logic exp_zero,
                       input int pulse, input bit hold);
        int loads;
        int shifts;
        int dcyc;
        bit got;
        loads = 0; shifts = 0; dcyc = 0; got = 0;
        @(negedge clk);
        op = o; amt = a; data_in = w; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 80 && !got; i++) begin
            @(negedge clk);
            if (!hold) start = (i == pulse);
            if (i == pulse) data_in = 32'h0000_0001;
            if (s == 2'b11) loads++;
            if (s == 2'b01 || s == 2'b10) shifts++;
            if (done) begin
                got = 1;
                dcyc = i;
            end
        end
        if (!hold) start = 1'b0;
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_done_cycle"}, dcyc, 3 + k);
        check({tag, "_cnt"}, 32'(shift_cnt), k);
        check({tag, "_q"}, q, exp_q);
        check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        check({tag, "_loads"}, loads, 1);
        check({tag, "_shifts"}, shifts, k);
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_s"}, 32'(s), 32'd0);
    endtask

    initial begin
        bit got;
        rst_n = 1'b0; start = 1'b0; op = 1'b0; amt = '0; data_in = '0;
        repeat (2) @(negedge clk);
        check("rst_s", 32'(s), 32'd0);
        check("rst_d", d, 32'd0);
        check("rst_slsr", {30'd0, sl, sr}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", 32'(shift_cnt), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        rst_n = 1'b1;

        // reset in the middle of a long normalize
        @(negedge clk);
        op = 1'b0; data_in = 32'h0000_0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy_before", 32'(busy), 32'd1);
        check("mid_s_before", 32'(s), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_s", 32'(s), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        got = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) got = 1;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) got = 1;
        end
        check("mid_no_done", 32'(got), 32'd0);

        run("norm_00f", 1'b0, 5'd0, 32'h00F0_0000, 8,
            32'hF000_0000, 1'b0, 0, 0);
        run("norm_zero", 1'b0, 5'd0, 32'h0000_0000, 0,
            32'h0000_0000, 1'b1, 0, 0);
        run("norm_one", 1'b0, 5'd0, 32'h0000_0001, 31,
            32'h8000_0000, 1'b0, 0, 0);
        run("norm_msb", 1'b0, 5'd0, 32'hC000_0000, 0,
            32'hC000_0000, 1'b0, 0, 0);
`ifdef SHIFT_ARITH_EN
        run("shr4", 1'b1, 5'd4, 32'h8000_0010, 4,
            32'hF800_0001, 1'b0, 0, 0);
        run("shr31", 1'b1, 5'd31, 32'hFFFF_FFFF, 31,
            32'hFFFF_FFFF, 1'b0, 0, 0);
`else
        run("shr4", 1'b1, 5'd4, 32'h8000_0010, 4,
            32'h0800_0001, 1'b0, 0, 0);
        run("shr31", 1'b1, 5'd31, 32'hFFFF_FFFF, 31,
            32'h0000_0001, 1'b0, 0, 0);
`endif
        run("shr0", 1'b1, 5'd0, 32'h1234_5678, 0,
            32'h1234_5678, 1'b0, 0, 0);
        run("busy_pulse", 1'b0, 5'd0, 32'h00F0_0000, 8,
            32'hF000_0000, 1'b0, 5, 0);

        // START held through DONE: the second command begins only from IDLE
        run("hold", 1'b0, 5'd0, 32'h4000_0000, 1,
            32'h8000_0000, 1'b0, 0, 1);
        @(negedge clk);
        check("hold_load_s", 32'(s), 32'd3);
        check("hold_load_busy", 32'(busy), 32'd1);
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        check("hold_second_done", 32'(got), 32'd1);
        check("hold_second_cnt", 32'(shift_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
